cla_sub_seq: RTL

- Multi-cycle registered subtractor. Computes a - b - bin over WIDTH bits, one 4-bit carry-look-ahead slice per clock, chaining the carry through a flop between cycles.
- Counterpart to the team's registered 4-bit CLA adder: it is the subtract direction, widened by iteration rather than by extra hardware.
- Sits behind a valid/ready request interface. Drives a held result with valid/ready back to the consumer.

---
 rtl/cla_pkg.sv | 17 +
 rtl/cla4_slice.sv | 29 ++
 rtl/cla_sub_seq.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the carry-look-ahead adder/subtractor family.
package cla_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement overflow of x + y = s from the sign bits; subtraction passes ~b as y.
    function automatic logic add_ovf(input logic x_msb, input logic y_msb, input logic s_msb);
        return (x_msb == y_msb) && (s_msb != x_msb);
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-look-ahead adder slice with fully expanded carries.
module cla4_slice
    import cla_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic               c1;
    logic               c2;
    logic               c3;

    assign g = a & b;
    assign p = a ^ b;

    assign c1   = g[0] | (p[0] & cin);
    assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/cla_sub_seq.sv
// Iterative subtractor: a - b - bin computed one 4-bit CLA slice per clock,
// carry held in a flop between slices, behind valid/ready on both sides.
module cla_sub_seq
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   bn_q;
    logic [WIDTH-1:0]   diff_q;
    logic [WIDTH-1:0]   diff_nx;
    logic               c_q;
    logic               bout_q;
    logic               ovf_q;
    logic               zero_q;
    logic               accept;
    logic               last;

    logic [SLICE_W-1:0] a_sl;
    logic [SLICE_W-1:0] b_sl;
    logic [SLICE_W-1:0] sum_sl;
    logic               cout_sl;

    // Single slice, time-multiplexed by the counter
    assign a_sl = a_q[int'(cnt_q) * SLICE_W +: SLICE_W];
    assign b_sl = bn_q[int'(cnt_q) * SLICE_W +: SLICE_W];

    cla4_slice u_slice (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (c_q),
        .sum  (sum_sl),
        .cout (cout_sl)
    );

    assign last = (state_q == RUN) && (cnt_q == LAST);

    always_comb begin
        diff_nx = diff_q;
        diff_nx[int'(cnt_q) * SLICE_W +: SLICE_W] = sum_sl;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        res_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The inverted borrow-in seeds the carry flop so slice 0 needs no special case
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q  <= '0;
            a_q    <= '0;
            bn_q   <= '0;
            c_q    <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            bn_q  <= ~b;
            c_q   <= ~bin;
            cnt_q <= '0;
        end else if (state_q == RUN) begin
            diff_q <= diff_nx;
            c_q    <= cout_sl;
            cnt_q  <= last ? '0 : cnt_q + 1'b1;
            if (last) begin
                bout_q <= ~cout_sl;
                ovf_q  <= add_ovf(a_q[WIDTH-1], bn_q[WIDTH-1], diff_nx[WIDTH-1]);
                zero_q <= (diff_nx == '0);
            end
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule
